// File: rtl/store_rmw_sequencer.sv
// -----------------------------------------------------------------------------
// store_rmw_sequencer
//   Multicycle sequencer for the store-size merge path.
//     sw      : single memory write of the B operand, store-size control 01.
//     sh / sb : read-modify-write. Read the target word, load it into the MDR,
//               then write back the merged word with store-size control 10/11.
//   All outputs are registered. Each output is computed from the next state,
//   so it is valid in the same cycle that the FSM occupies that state.
//
// Optional feature (macro STORE_SEQ_MISALIGN_TRAP_EN):
//   A misaligned sw/sh is trapped on accept. The FSM goes IDLE -> DONE and
//   raises o_exc_misalign together with o_done. No memory strobe is issued.
//   Without the macro the o_exc_misalign port does not exist.
//
// Parameters:
//   ADDR_WIDTH      byte address width
//   MEM_RD_LATENCY  cycles from a mem_rd cycle to read data valid (>= 1)
//
// Ports:
//   i_clk          system clock, rising edge
//   i_reset        asynchronous, active-high reset
//   i_start        store request, sampled only in IDLE
//   i_store_type   01 sw, 10 sh, 11 sb, 00 none; sampled with i_start
//   i_addr         store address; sampled with i_start
//   o_busy         high in every state except IDLE
//   o_done         one-cycle store-complete pulse
//   o_mem_addr     latched store address
//   o_mem_rd       memory read strobe
//   o_mem_wr       memory write strobe
//   o_mdr_load     memory data register load enable
//   o_ss_control   store-size select, latched type while busy, 00 in IDLE
//   o_exc_misalign misaligned-store exception pulse (macro builds only)
// -----------------------------------------------------------------------------
module store_rmw_sequencer #(
  parameter int ADDR_WIDTH     = 32,
  parameter int MEM_RD_LATENCY = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [1:0]            i_store_type,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_rd,
  output logic                  o_mem_wr,
  output logic                  o_mdr_load,
  output logic [1:0]            o_ss_control
`ifdef STORE_SEQ_MISALIGN_TRAP_EN
  ,
  output logic                  o_exc_misalign
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_LATCH = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // Counter only has to hold MEM_RD_LATENCY-1; keep at least one bit.
  localparam int               CNT_W    = (MEM_RD_LATENCY > 1) ? $clog2(MEM_RD_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_RD_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [2:0]            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [1:0]            r_type;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_mem_rd;
  logic                  r_mem_wr;
  logic                  r_mdr_load;
  logic [1:0]            r_ss_control;
  logic                  r_exc;

  logic       w_accept;
  logic       w_misalign;
  logic [2:0] w_next_state;
  logic [1:0] w_type_next;
  logic       w_exc_next;

  // Accept decode and misalignment classification of the incoming store.
  always_comb begin
    w_accept = (r_state == S_IDLE) && i_start && (i_store_type != 2'b00);
`ifdef STORE_SEQ_MISALIGN_TRAP_EN
    w_misalign = ((i_store_type == 2'b01) && (i_addr[1:0] != 2'b00)) ||
                 ((i_store_type == 2'b10) && i_addr[0]);
`else
    w_misalign = 1'b0;
`endif
    if (w_accept) begin
      w_type_next = i_store_type;
    end else begin
      w_type_next = r_type;
    end
  end

  // Next-state logic; the exception flag is only raised on a trapped accept.
  always_comb begin
    w_next_state = r_state;
    w_exc_next   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_misalign) begin
            w_next_state = S_DONE;
            w_exc_next   = 1'b1;
          end else if (i_store_type == 2'b01) begin
            w_next_state = S_WRITE;
          end else begin
            w_next_state = S_READ;
          end
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_READ: begin
        if (CNT_INIT != CNT_ZERO) begin
          w_next_state = S_WAIT;
        end else begin
          w_next_state = S_LATCH;
        end
      end
      // Leave WAIT on the cycle the counter decrements to zero.
      S_WAIT: begin
        if (r_cnt <= CNT_ONE) begin
          w_next_state = S_LATCH;
        end else begin
          w_next_state = S_WAIT;
        end
      end
      S_LATCH: w_next_state = S_WRITE;
      S_WRITE: w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State, latched transaction fields and read-latency counter.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= CNT_ZERO;
      r_type     <= 2'b00;
      r_mem_addr <= {ADDR_WIDTH{1'b0}};
    end else begin
      r_state <= w_next_state;
      r_type  <= w_type_next;
      if (w_accept) begin
        r_mem_addr <= i_addr;
      end
      if (r_state == S_READ) begin
        r_cnt <= CNT_INIT;
      end else if ((r_state == S_WAIT) && (r_cnt != CNT_ZERO)) begin
        r_cnt <= r_cnt - CNT_ONE;
      end
    end
  end

  // Registered outputs decoded from the next state so they align with it.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mdr_load   <= 1'b0;
      r_ss_control <= 2'b00;
      r_exc        <= 1'b0;
    end else begin
      r_busy       <= (w_next_state != S_IDLE);
      r_done       <= (w_next_state == S_DONE);
      r_mem_rd     <= (w_next_state == S_READ);
      r_mem_wr     <= (w_next_state == S_WRITE);
      r_mdr_load   <= (w_next_state == S_LATCH);
      r_ss_control <= (w_next_state == S_IDLE) ? 2'b00 : w_type_next;
      r_exc        <= w_exc_next;
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_rd     = r_mem_rd;
  assign o_mem_wr     = r_mem_wr;
  assign o_mdr_load   = r_mdr_load;
  assign o_ss_control = r_ss_control;
`ifdef STORE_SEQ_MISALIGN_TRAP_EN
  assign o_exc_misalign = r_exc;
`else
  logic w_unused;
  assign w_unused = r_exc;
`endif

endmodule

// File: tb/tb_store_rmw_sequencer.sv
// -----------------------------------------------------------------------------
// tb_store_rmw_sequencer
//   Directed bench. Instance 0 uses MEM_RD_LATENCY=1, instance 1 uses
//   MEM_RD_LATENCY=3. A small memory + MDR + merge model reacts to the DUT
//   strobes so the merged memory words can be compared against hand-computed
//   values. Unwritten memory words read back as 32'hAABBCCDD. The B operand is
//   fixed at 32'h11223344.
// -----------------------------------------------------------------------------
module tb_store_rmw_sequencer;

  localparam logic [31:0] B_OP     = 32'h11223344;
  localparam logic [31:0] MEM_INIT = 32'hAABBCCDD;

  logic        clk;
  logic        rst;
  logic        start [2];
  logic [1:0]  stype [2];
  logic [31:0] addr  [2];
  logic        busy  [2];
  logic        done  [2];
  logic [31:0] maddr [2];
  logic        mrd   [2];
  logic        mwr   [2];
  logic        mld   [2];
  logic [1:0]  ss    [2];
`ifdef STORE_SEQ_MISALIGN_TRAP_EN
  logic        exc   [2];
`endif

  logic [31:0] mem    [2][256];
  logic        mvalid [2][256];
  logic [31:0] mdr    [2];
  int          rd_cnt [2];
  int          wr_cnt [2];
  int          ld_cnt [2];
  int          dn_cnt [2];
  int          viol;

  int total;
  int bad;

  store_rmw_sequencer #(.ADDR_WIDTH(32), .MEM_RD_LATENCY(1)) u_dut0 (
    .i_clk(clk), .i_reset(rst), .i_start(start[0]), .i_store_type(stype[0]),
    .i_addr(addr[0]), .o_busy(busy[0]), .o_done(done[0]), .o_mem_addr(maddr[0]),
    .o_mem_rd(mrd[0]), .o_mem_wr(mwr[0]), .o_mdr_load(mld[0]), .o_ss_control(ss[0])
`ifdef STORE_SEQ_MISALIGN_TRAP_EN
    , .o_exc_misalign(exc[0])
`endif
  );

  store_rmw_sequencer #(.ADDR_WIDTH(32), .MEM_RD_LATENCY(3)) u_dut1 (
    .i_clk(clk), .i_reset(rst), .i_start(start[1]), .i_store_type(stype[1]),
    .i_addr(addr[1]), .o_busy(busy[1]), .o_done(done[1]), .o_mem_addr(maddr[1]),
    .o_mem_rd(mrd[1]), .o_mem_wr(mwr[1]), .o_mdr_load(mld[1]), .o_ss_control(ss[1])
`ifdef STORE_SEQ_MISALIGN_TRAP_EN
    , .o_exc_misalign(exc[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mword(input int k, input int idx);
    return mvalid[k][idx] ? mem[k][idx] : MEM_INIT;
  endfunction

  // Memory, MDR and merge-unit model plus strobe counters.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mrd[k] && mwr[k]) viol <= viol + 1;
      if (mrd[k]) rd_cnt[k] <= rd_cnt[k] + 1;
      if (done[k]) dn_cnt[k] <= dn_cnt[k] + 1;
      if (mld[k]) begin
        mdr[k]    <= mword(k, int'(maddr[k][9:2]));
        ld_cnt[k] <= ld_cnt[k] + 1;
      end
      if (mwr[k]) begin
        wr_cnt[k] <= wr_cnt[k] + 1;
        mvalid[k][maddr[k][9:2]] <= 1'b1;
        case (ss[k])
          2'b01:   mem[k][maddr[k][9:2]] <= B_OP;
          2'b10:   mem[k][maddr[k][9:2]] <= {mdr[k][31:16], B_OP[15:0]};
          2'b11:   mem[k][maddr[k][9:2]] <= {mdr[k][31:8], B_OP[7:0]};
          default: mem[k][maddr[k][9:2]] <= 32'hDEADDEAD;
        endcase
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int k, input logic [1:0] t, input logic [31:0] a);
    start[k] = 1'b1;
    stype[k] = t;
    addr[k]  = a;
  endtask

  int w0, d0, r0, l0;

  initial begin
    total = 0;
    bad   = 0;
    viol  = 0;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; stype[k] = 2'b00; addr[k] = 32'h0;
      rd_cnt[k] = 0; wr_cnt[k] = 0; ld_cnt[k] = 0; dn_cnt[k] = 0;
      mdr[k] = 32'h0;
      for (int i = 0; i < 256; i++) mvalid[k][i] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) cyc();
    for (int k = 0; k < 2; k++) begin
      chk("rst_busy", busy[k], 1'b0);
      chk("rst_done", done[k], 1'b0);
      chk("rst_strobes", {mrd[k], mwr[k], mld[k]}, 3'b000);
      chk("rst_ss", ss[k], 2'b00);
      chk("rst_addr", maddr[k], 32'h0);
`ifdef STORE_SEQ_MISALIGN_TRAP_EN
      chk("rst_exc", exc[k], 1'b0);
`endif
    end
    rst = 1'b0;
    cyc();

    // sw to 0x100, latency 1; start held into DONE then IDLE (back-to-back)
    go(0, 2'b01, 32'h100);
    cyc();
    start[0] = 1'b0;
    chk("sw_wr", mwr[0], 1'b1);
    chk("sw_ss", ss[0], 2'b01);
    chk("sw_addr", maddr[0], 32'h100);
    chk("sw_rd", mrd[0], 1'b0);
    chk("sw_busy", busy[0], 1'b1);
    cyc();
    chk("sw_done", done[0], 1'b1);
    chk("sw_wr_off", mwr[0], 1'b0);
    start[0] = 1'b1;
    cyc();
    chk("sw_idle_busy", busy[0], 1'b0);
    chk("done_no_accept", mwr[0], 1'b0);
    cyc();
    start[0] = 1'b0;
    chk("b2b_wr", mwr[0], 1'b1);
    cyc();
    chk("b2b_done", done[0], 1'b1);
    cyc();
    chk("sw_mem", mword(0, 32'h40), 32'h11223344);

    // sh to 0x204, latency 1
    go(0, 2'b10, 32'h204);
    cyc();
    start[0] = 1'b0;
    chk("sh_rd", {mrd[0], mwr[0], mld[0]}, 3'b100);
    cyc();
    chk("sh_ld", {mrd[0], mwr[0], mld[0]}, 3'b001);
    cyc();
    chk("sh_wr", {mrd[0], mwr[0], mld[0]}, 3'b010);
    chk("sh_ss", ss[0], 2'b10);
    cyc();
    chk("sh_done", done[0], 1'b1);
    cyc();
    chk("sh_mem", mword(0, 32'h81), 32'hAABB3344);
    chk("sh_busy_end", busy[0], 1'b0);

    // sb to 0x300, latency 3
    go(1, 2'b11, 32'h300);
    cyc();
    start[1] = 1'b0;
    chk("sb_rd", {mrd[1], mwr[1], mld[1]}, 3'b100);
    cyc();
    chk("sb_wait1", {busy[1], mrd[1], mwr[1], mld[1]}, 4'b1000);
    cyc();
    chk("sb_wait2", {busy[1], mrd[1], mwr[1], mld[1]}, 4'b1000);
    cyc();
    chk("sb_ld", {mrd[1], mwr[1], mld[1]}, 3'b001);
    cyc();
    chk("sb_wr", {mrd[1], mwr[1], mld[1]}, 3'b010);
    chk("sb_ss", ss[1], 2'b11);
    cyc();
    chk("sb_done", done[1], 1'b1);
    cyc();
    chk("sb_mem", mword(1, 32'hC0), 32'hAABBCC44);

    // sw start while an sh is busy must be ignored
    w0 = wr_cnt[0];
    d0 = dn_cnt[0];
    go(0, 2'b10, 32'h208);
    cyc();
    go(0, 2'b01, 32'h3F0);
    cyc();
    start[0] = 1'b0;
    chk("busy_addr", maddr[0], 32'h208);
    chk("busy_ss", ss[0], 2'b10);
    repeat (5) cyc();
    chk("busy_wr_cnt", wr_cnt[0] - w0, 1);
    chk("busy_done_cnt", dn_cnt[0] - d0, 1);
    chk("busy_addr_end", maddr[0], 32'h208);
    chk("busy_mem_sh", mword(0, 32'h82), 32'hAABB3344);
    chk("busy_mem_sw", mword(0, 32'hFC), 32'hAABBCCDD);

    // reset during WAIT of an sb
    w0 = wr_cnt[1];
    go(1, 2'b11, 32'h310);
    cyc();
    start[1] = 1'b0;
    cyc();
    chk("pre_rst_busy", busy[1], 1'b1);
    rst = 1'b1;
    #1;
    chk("arst_busy", busy[1], 1'b0);
    chk("arst_strobes", {mrd[1], mwr[1], mld[1], done[1]}, 4'b0000);
    chk("arst_ss", ss[1], 2'b00);
    chk("arst_addr", maddr[1], 32'h0);
    cyc();
    rst = 1'b0;
    repeat (6) cyc();
    chk("rst_no_wr", wr_cnt[1] - w0, 0);
    chk("rst_idle", {busy[1], ss[1]}, 3'b000);
    chk("rst_mem", mword(1, 32'hC4), 32'hAABBCCDD);

    // store_type 00 is ignored
    d0 = dn_cnt[0];
    go(0, 2'b00, 32'h500);
    cyc();
    start[0] = 1'b0;
    chk("none_busy", busy[0], 1'b0);
    cyc();
    chk("none_done", dn_cnt[0] - d0, 0);

    // sw to 0x102: trapped with the macro, written through without it
    w0 = wr_cnt[0];
    r0 = rd_cnt[0];
    l0 = ld_cnt[0];
    go(0, 2'b01, 32'h102);
    cyc();
    start[0] = 1'b0;
`ifdef STORE_SEQ_MISALIGN_TRAP_EN
    chk("mis_done", done[0], 1'b1);
    chk("mis_exc", exc[0], 1'b1);
    chk("mis_busy", busy[0], 1'b1);
    cyc();
    chk("mis_exc_off", {exc[0], busy[0]}, 2'b00);
    chk("mis_no_strobes", (wr_cnt[0] - w0) + (rd_cnt[0] - r0) + (ld_cnt[0] - l0), 0);
`else
    chk("unal_wr", mwr[0], 1'b1);
    chk("unal_addr", maddr[0], 32'h102);
    cyc();
    chk("unal_done", done[0], 1'b1);
    cyc();
    chk("unal_cnt", (wr_cnt[0] - w0) + (rd_cnt[0] - r0) + (ld_cnt[0] - l0), 1);
`endif
    cyc();
    chk("rd_wr_exclusive", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_rmw_sequencer.md
Name: store_rmw_sequencer

Overview:
- Multicycle FSM that sequences the store-size merge path: sw, sh, sb.
- sw: issues a single memory write of the B operand, with store-size control 01.
- sh/sb: read-modify-write. Reads the target word, loads it into the memory data register, then writes back the merged word with store-size control 10 or 11.
- Sits between the main control unit and the memory / MDR / store-size merge unit. The main control hands over a store and waits for done.

Parameters:
- ADDR_WIDTH, 32, width of the byte address.
- MEM_RD_LATENCY, 1, cycles from a mem_rd cycle to read data valid at the MDR input. Legal range >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a store; sampled only in IDLE.
- store_type  input  2  01 sw, 10 sh, 11 sb, 00 none; sampled with start.
- addr  input  ADDR_WIDTH  store address; sampled with start.
- busy  output  1  high from the cycle after start is accepted until DONE is left.
- done  output  1  one-cycle pulse; store complete.
- mem_addr  output  ADDR_WIDTH  latched store address driven to memory.
- mem_rd  output  1  memory read strobe.
- mem_wr  output  1  memory write strobe.
- mdr_load  output  1  memory data register load enable.
- ss_control  output  2  store-size select to the merge unit.
- exc_misalign  output  1  misaligned-store exception pulse; present only with the macro.

Behaviour:
- Clock and reset: one clock domain (clk). reset is asynchronous and active-high.
- Reset values: state IDLE; busy, done, mem_rd, mem_wr, mdr_load, exc_misalign all 0; ss_control 00; mem_addr 0; wait counter 0.
- States: IDLE, READ, WAIT, LATCH, WRITE, DONE.
- IDLE:
  - start=1 with store_type != 00: latch addr and store_type.
  - Latched type 01 goes to WRITE; 10 or 11 goes to READ.
  - start with store_type=00 is ignored: stay IDLE, no done.
- READ:
  - mem_rd=1 for exactly one cycle.
  - Load the wait counter with MEM_RD_LATENCY-1.
  - Go to WAIT if the counter value is nonzero, else to LATCH.
- WAIT: decrement the counter each cycle; go to LATCH when it reaches 0. Total WAIT cycles = MEM_RD_LATENCY-1.
- LATCH: mdr_load=1 for exactly one cycle, then go to WRITE.
- WRITE: mem_wr=1 for exactly one cycle, with ss_control = latched type; then go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- busy: 1 in every state except IDLE.
- mem_addr: holds the latched address stable for the whole transaction.
- ss_control: equals the latched type in every non-IDLE state; 00 in IDLE.
- Latency from the start edge to the done cycle:
  - sw: 2 cycles (WRITE, DONE).
  - sh/sb: MEM_RD_LATENCY+3 cycles.
- Strobes: mem_rd and mem_wr are never high in the same cycle. mem_wr is never high before mdr_load for sh/sb.
- start while busy: ignored. No queuing, no change to latched values.
- reset mid-transaction: immediate return to IDLE with all strobes 0. A pending write is never issued after reset deasserts.
- Back-to-back: a new start is accepted in the first IDLE cycle after DONE. There is no start acceptance in DONE itself.
- Address: low address bits are passed through unmodified. The merge unit always places data in the low bytes.

Optional Feature:
- Macro: STORE_SEQ_MISALIGN_TRAP_EN.
- With the macro defined:
  - On accept, the store is checked: sw with addr[1:0] != 00, or sh with addr[0] != 0, is misaligned.
  - A misaligned store goes IDLE -> DONE. exc_misalign=1 and done=1 in that DONE cycle, with no mem_rd, mem_wr or mdr_load.
  - sb is never misaligned.
- Without the macro: the exc_misalign port does not exist, and all stores proceed regardless of the low address bits.

Test Plan:
- sw to 0x100, MEM_RD_LATENCY=1, start one cycle:
  - Cycle +1: mem_wr=1, ss_control=01, mem_addr=0x100, mem_rd=0.
  - Cycle +2: done=1.
  - Cycle +3: busy=0.
- sh to 0x204, MEM_RD_LATENCY=1:
  - Cycle +1: mem_rd. Cycle +2: mdr_load. Cycle +3: mem_wr with ss_control=10. Cycle +4: done.
  - With memory word 0xAABBCCDD and B=0x11223344, memory afterwards = 0xAABB3344.
- sb to 0x300, MEM_RD_LATENCY=3:
  - mem_rd at +1, WAIT at +2/+3, mdr_load at +4, mem_wr with ss_control=11 at +5, done at +6.
  - With memory word 0xAABBCCDD and B=0x11223344, memory afterwards = 0xAABBCC44.
- start pulsed with sw while an sh is busy: no extra mem_wr, mem_addr unchanged, exactly one done pulse.
- reset asserted during WAIT of an sb: all outputs 0 asynchronously, no mem_wr in any later cycle, FSM in IDLE.
- With STORE_SEQ_MISALIGN_TRAP_EN, sw to 0x102: cycle +1 has done=1 and exc_misalign=1, with mem_rd, mem_wr and mdr_load never asserted.
